// File: rtl/regfile_multiport.sv
// Multi-port register file with write-through bypass, prioritised debug/pipeline
// write ports and a hardware clear sequence that walks every entry after reset.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       RegWrite,
  input  logic [ADDR_W-1:0]          WriteSelect,
  input  logic [DATA_W-1:0]          WriteData,
  input  logic                       DbgWrite,
  input  logic [ADDR_W-1:0]          DbgSelect,
  input  logic [DATA_W-1:0]          DbgData,
  input  logic                       ClearReq,
  input  logic [NUM_RD*ADDR_W-1:0]   ReadSelect,
  output logic [NUM_RD*DATA_W-1:0]   ReadData,
  output logic                       Busy,
  output logic                       WriteDropped
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_clr_cnt_nxt;
  logic                r_drop;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_ready;
  logic                w_wen;
  logic                w_wr_ok;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;

  assign w_ready = (r_state == S_READY);

  // Debug port has fixed priority; only the winner is stored or forwarded.
  assign w_wen   = w_ready && (DbgWrite || RegWrite);
  assign w_waddr = DbgWrite ? DbgSelect : WriteSelect;
  assign w_wdata = DbgWrite ? DbgData   : WriteData;
  assign w_wr_ok = w_wen && !((ZERO_REG != 0) && (w_waddr == '0));

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == {ADDR_W{1'b1}}) w_state_nxt = S_READY;
      end
      S_READY: begin
        if (ClearReq) begin
          w_state_nxt   = S_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = S_CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_drop    <= w_ready && DbgWrite && RegWrite;
    end
  end

  // Storage is not reset directly; the clear walk zeroes it after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (!w_ready)     r_mem[r_clr_cnt] <= '0;
      else if (w_wr_ok) r_mem[w_waddr]   <= w_wdata;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_sel;
    logic [DATA_W-1:0] w_rd;

    assign w_sel = ReadSelect[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_rd = '0;
      if (!w_ready)                               w_rd = '0;
      else if ((ZERO_REG != 0) && (w_sel == '0))  w_rd = '0;
      else if (w_wen && (w_waddr == w_sel))       w_rd = w_wdata;
      else                                        w_rd = r_mem[w_sel];
    end

    assign ReadData[i*DATA_W +: DATA_W] = w_rd;
  end

  assign Busy         = (r_state == S_CLEAR);
  assign WriteDropped = r_drop;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: two builds (NUM_RD=2/ZERO_REG=1 and NUM_RD=4/ZERO_REG=0)
// share one write/clear stimulus stream and are checked against hand values.
module tb_regfile_multiport;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         RegWrite, DbgWrite, ClearReq;
  logic [4:0]   WriteSelect, DbgSelect;
  logic [31:0]  WriteData, DbgData;
  logic [9:0]   rs_a;
  logic [63:0]  rd_a;
  logic         busy_a, drop_a;
  logic [19:0]  rs_b;
  logic [127:0] rd_b;
  logic         busy_b, drop_b;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_dut_a (
    .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WriteSelect(WriteSelect),
    .WriteData(WriteData), .DbgWrite(DbgWrite), .DbgSelect(DbgSelect),
    .DbgData(DbgData), .ClearReq(ClearReq), .ReadSelect(rs_a), .ReadData(rd_a),
    .Busy(busy_a), .WriteDropped(drop_a)
  );

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WriteSelect(WriteSelect),
    .WriteData(WriteData), .DbgWrite(DbgWrite), .DbgSelect(DbgSelect),
    .DbgData(DbgData), .ClearReq(ClearReq), .ReadSelect(rs_b), .ReadData(rd_b),
    .Busy(busy_b), .WriteDropped(drop_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Counts cycles with Busy high (bounded) and flags any nonzero read or drop pulse.
  task automatic run_busy(input string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (busy_a && n < 40) begin
      if (rd_a != '0 || rd_b != '0 || drop_a || drop_b) bad++;
      n++;
      tick();
    end
    chk({tag, "_busy_len"}, n, 32);
    chk({tag, "_quiet"}, bad, 0);
    chk({tag, "_busy_b"}, {31'd0, busy_b}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      rs_a = {2{a[4:0]}};
      rs_b = {4{a[4:0]}};
      #1;
      if (rd_a != '0 || rd_b != '0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    Reset = 1'b0; RegWrite = 0; DbgWrite = 0; ClearReq = 0;
    WriteSelect = '0; DbgSelect = '0; WriteData = '0; DbgData = '0;
    rs_a = '0; rs_b = '0;

    // reset and initial clear
    tick(); tick();
    chk("rst_busy", {31'd0, busy_a}, 1);
    chk("rst_drop", {31'd0, drop_a}, 0);
    Reset = 1'b1;
    rs_a = {5'd7, 5'd3};
    rs_b = {5'd31, 5'd3, 5'd2, 5'd1};
    run_busy("init");
    check_all_zero("init_zero");

    // same-cycle bypass then stored value
    RegWrite = 1; WriteSelect = 5'd5; WriteData = 32'hDEADBEEF;
    rs_a = {5'd0, 5'd5}; rs_b = {15'd0, 5'd5};
    #1;
    chk("byp_a", rd_a[31:0], 32'hDEADBEEF);
    chk("byp_b", rd_b[31:0], 32'hDEADBEEF);
    tick();
    RegWrite = 0;
    #1;
    chk("stored_a", rd_a[31:0], 32'hDEADBEEF);

    // debug wins, pipeline write dropped and not forwarded
    DbgWrite = 1; DbgSelect = 5'd3; DbgData = 32'h11;
    RegWrite = 1; WriteSelect = 5'd4; WriteData = 32'h22;
    rs_a = {5'd4, 5'd3};
    #1;
    chk("arb_p0", rd_a[31:0], 32'h11);
    chk("arb_p1", rd_a[63:32], 32'h0);
    chk("arb_drop_pre", {31'd0, drop_a}, 0);
    tick();
    DbgWrite = 0; RegWrite = 0;
    #1;
    chk("arb_drop", {31'd0, drop_a}, 1);
    chk("arb_e3", rd_a[31:0], 32'h11);
    chk("arb_e4", rd_a[63:32], 32'h0);
    tick();
    chk("arb_drop_end", {31'd0, drop_a}, 0);

    // entry 0 behaviour per build
    RegWrite = 1; WriteSelect = 5'd0; WriteData = 32'hFFFFFFFF;
    rs_a = '0; rs_b = '0;
    #1;
    chk("z0_a_now", rd_a[31:0], 32'h0);
    chk("z0_b_now", rd_b[31:0], 32'hFFFFFFFF);
    tick();
    RegWrite = 0;
    #1;
    chk("z0_a_next", rd_a[31:0], 32'h0);
    chk("z0_b_next", rd_b[31:0], 32'hFFFFFFFF);

    // fill 1..31 with index, check four independent ports
    for (int i = 1; i < 32; i++) begin
      RegWrite = 1; WriteSelect = i[4:0]; WriteData = i;
      tick();
    end
    RegWrite = 0;
    rs_b = {5'd31, 5'd3, 5'd2, 5'd1};
    rs_a = {5'd9, 5'd9};
    #1;
    chk("fill_b0", rd_b[31:0], 32'd1);
    chk("fill_b1", rd_b[63:32], 32'd2);
    chk("fill_b2", rd_b[95:64], 32'd3);
    chk("fill_b3", rd_b[127:96], 32'd31);
    chk("fill_a_same", rd_a[63:32], rd_a[31:0] ^ 32'd0 ^ 32'd9 ^ 32'd9);
    chk("fill_a9", rd_a[31:0], 32'd9);

    // ClearReq with a concurrent write; writes held through the clear
    ClearReq = 1; RegWrite = 1; WriteSelect = 5'd7; WriteData = 32'h77;
    rs_a = {5'd3, 5'd7};
    #1;
    chk("clr_byp", rd_a[31:0], 32'h77);
    tick();
    ClearReq = 0;
    DbgWrite = 1; DbgSelect = 5'd3; DbgData = 32'h33;
    WriteSelect = 5'd3; WriteData = 32'h44;
    run_busy("req");
    DbgWrite = 0; RegWrite = 0;
    check_all_zero("req_zero");

    // reset mid-clear restarts the walk from entry 0
    ClearReq = 1;
    tick();
    ClearReq = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", {31'd0, busy_a}, 1);
    Reset = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    run_busy("mid");
    check_all_zero("mid_zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the pipeline's general-purpose register file.
- Provides NUM_RD combinational read ports with same-cycle write-through bypass, which removes the WB->ID hazard.
- Has one pipeline write port and one debug/bench write port with fixed priority.
- Runs a hardware clear sequence after reset or on request.
- Sits between ID (read select and read data) and WB (write-back); the debug port replaces the ad-hoc temp write inputs used by benches.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, select width; depth = 2**ADDR_W entries
- NUM_RD, 2, number of read ports
- ZERO_REG, 1, when 1, entry 0 reads 0 and ignores writes

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low reset
- RegWrite  in  1  pipeline write enable (WB stage)
- WriteSelect  in  ADDR_W  pipeline write address
- WriteData  in  DATA_W  pipeline write data
- DbgWrite  in  1  debug write enable
- DbgSelect  in  ADDR_W  debug write address
- DbgData  in  DATA_W  debug write data
- ClearReq  in  1  one-cycle request to zero the whole file
- ReadSelect  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- ReadData  out  NUM_RD*DATA_W  packed read data, same packing
- Busy  out  1  high while the clear sequence runs
- WriteDropped  out  1  registered one-cycle pulse: pipeline write was lost

Behaviour:
- States: CLEAR, READY. Clear counter ClrCnt is ADDR_W bits wide.
- Reset low at an edge:
  - state <= CLEAR, ClrCnt <= 0, WriteDropped <= 0.
  - Entries are not written while Reset is low.
  - Busy = 1 from the first edge with Reset low.
- CLEAR with Reset high:
  - Each edge writes 0 to entry ClrCnt, then ClrCnt <= ClrCnt+1.
  - On the edge that clears entry 2**ADDR_W-1, state <= READY and ClrCnt wraps to 0.
  - Busy therefore stays high for exactly 2**ADDR_W cycles after Reset is released.
  - Busy is a combinational decode of state.
- CLEAR, other rules:
  - All writes are ignored; WriteDropped is not asserted for them.
  - ClearReq is ignored.
  - All ReadData ports read 0, with no bypass.
- READY, ClearReq=1: state <= CLEAR, ClrCnt <= 0. Any write presented in that same cycle is still performed.
- READY, write arbitration:
  - DbgWrite=1: entry DbgSelect <= DbgData.
  - Otherwise RegWrite=1: entry WriteSelect <= WriteData.
  - Both asserted: the debug write wins; the pipeline write is discarded; WriteDropped <= 1 at that edge (also when the addresses differ). Otherwise WriteDropped <= 0.
  - A write to entry 0 has no effect when ZERO_REG=1.
- READY, read (combinational, per port i):
  - Address 0 with ZERO_REG=1 -> 0.
  - Else, if the winning write this cycle is enabled and its address equals ReadSelect[i] -> that write's data (write-through bypass).
  - Else the stored entry.
  - Bypass uses the arbitrated write only; a dropped pipeline write is never forwarded.
- Writes and ClearReq never corrupt reads of unrelated addresses in the same cycle.
- Reset low mid-clear restarts at ClrCnt=0. Reset low in READY discards any writes presented that cycle.
- All ports are independent; several ports may read the same address.
- Implementation: entries in a flop array, with a generate loop over read ports.

Test Plan:
- Reset low 2 cycles, then high -> Busy=1 for exactly 32 cycles; ReadData=0 throughout; Busy=0 on cycle 33; every entry reads 0.
- READY, RegWrite=1, WriteSelect=5, WriteData=0xDEADBEEF, port0 ReadSelect=5 in the same cycle -> port0 = 0xDEADBEEF before the edge; still 0xDEADBEEF after the edge with RegWrite=0.
- DbgWrite=1 (sel 3, 0x11), RegWrite=1 (sel 4, 0x22), both ports reading 3 and 4 -> reads 0x11 and stored value of 4 (0); next cycle entry4 unchanged; WriteDropped=1 for one cycle.
- RegWrite=1, sel 0, data 0xFFFFFFFF, ZERO_REG=1 -> read of 0 is 0 in the same and next cycle; repeat with ZERO_REG=0 -> reads 0xFFFFFFFF.
- Fill entries 1..31 with their index, pulse ClearReq with RegWrite to entry 7 = 0x77 -> Busy high 32 cycles, writes during CLEAR ignored, all entries 0 afterwards.
- Reset low during CLEAR at ClrCnt=10, then high -> Busy lasts a full 32 further cycles; NUM_RD=4 build: four ports read distinct addresses 1,2,3,31 correctly.
